// File: rtl/watchdog_gen_if.sv
// 68k bus signals the watchdog snoops to detect a kick write.
interface watchdog_gen_if;
    logic       nLDS;
    logic       RW;
    logic [6:0] M68K_ADDR_U;

    modport master (output nLDS, output RW, output M68K_ADDR_U);
    modport slave  (input  nLDS, input  RW, input  M68K_ADDR_U);
endinterface

// File: rtl/watchdog_gen.sv
// NeoGeo 68k watchdog: trips nRESET/nHALT after TRIP unkicked WDCLK ticks, holds for HOLD ticks.
// Optional pre-timeout WARN output is built when WATCHDOG_WARN_EN is defined.
module watchdog_gen #(
    parameter int         CNT_W   = 4,
    parameter int         TRIP    = 8,
    parameter int         HOLD    = 8,
    parameter logic [6:0] KICK_A  = 7'b0011000,
    parameter int         WARN_AT = 6
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               DOGE,
    input  logic               WDCLK,
    watchdog_gen_if.slave      bus,
    output logic               nRESET,
    output logic               nHALT,
    output logic               WARN,
    output logic [7:0]         TRIPS
);

    typedef enum logic {ARMED, BITE} state_t;

    localparam logic [CNT_W-1:0] TRIP_LAST = CNT_W'(TRIP - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             wdclk_d;
    logic             nreset_q;
    logic [7:0]       trips_q;
    logic             kick;
    logic             tick;

    assign kick = ~bus.nLDS & ~bus.RW & (bus.M68K_ADDR_U == KICK_A);
    assign tick = WDCLK & ~wdclk_d;

    // The counter is cleared by its compare before it can wrap, so both limits must fit in CNT_W.
    assert property (@(posedge CLK) (TRIP >= 1) && (TRIP < (1 << CNT_W)) &&
                                    (HOLD >= 1) && (HOLD < (1 << CNT_W)) &&
                                    (WARN_AT < TRIP));

    always_ff @(posedge CLK) begin
        wdclk_d <= WDCLK;
        if (RST) begin
            state    <= BITE;
            cnt      <= '0;
            trips_q  <= 8'd0;
            nreset_q <= 1'b0;
        end else begin
            nreset_q <= (state == ARMED);
            if (!DOGE) begin
                state <= ARMED;
                cnt   <= '0;
            end else if (state == ARMED) begin
                if (kick) begin
                    cnt <= '0;
                end else if (tick) begin
                    if (cnt == TRIP_LAST) begin
                        state <= BITE;
                        cnt   <= '0;
                        if (trips_q != 8'hFF) begin
                            trips_q <= trips_q + 8'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            end else if (tick) begin
                // Kicks are ignored here: the CPU is being held in reset.
                if (cnt == HOLD_LAST) begin
                    state <= ARMED;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign nRESET = nreset_q;
    assign nHALT  = nreset_q;
    assign TRIPS  = trips_q;

`ifdef WATCHDOG_WARN_EN
    localparam logic [CNT_W-1:0] WARN_LVL = CNT_W'(WARN_AT);

    logic warn_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            warn_q <= 1'b0;
        end else begin
            warn_q <= DOGE && (state == ARMED) && (cnt >= WARN_LVL);
        end
    end

    assign WARN = warn_q;
`else
    assign WARN = 1'b0;
`endif

endmodule

// File: tb/tb_watchdog_gen.sv
// Scoreboard bench for watchdog_gen: stimulus pushes expected outputs, a negedge monitor compares.
module tb_watchdog_gen;

    localparam logic [6:0] KICK_ADDR = 7'b0011000;

    logic       CLK = 1'b0;
    logic       RST;
    logic       DOGE;
    logic       WDCLK;
    logic       nRESET;
    logic       nHALT;
    logic       WARN;
    logic [7:0] TRIPS;

    watchdog_gen_if bus ();

    watchdog_gen dut (
        .CLK    (CLK),
        .RST    (RST),
        .DOGE   (DOGE),
        .WDCLK  (WDCLK),
        .bus    (bus.slave),
        .nRESET (nRESET),
        .nHALT  (nHALT),
        .WARN   (WARN),
        .TRIPS  (TRIPS)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string      name;
        logic       nres;
        logic [7:0] trips;
        logic       warn;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // Monitor: every pending expectation is compared against the outputs on the falling edge.
    always @(negedge CLK) begin
        while (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            checks++;
            if (nRESET !== e.nres || nHALT !== e.nres || TRIPS !== e.trips || WARN !== e.warn) begin
                errors++;
                $display("[TB] FAIL %s: got nRESET=%b nHALT=%b TRIPS=%0d WARN=%b, expected nRESET=%b nHALT=%b TRIPS=%0d WARN=%b",
                         e.name, nRESET, nHALT, TRIPS, WARN, e.nres, e.nres, e.trips, e.warn);
            end
        end
    end

    function automatic logic warnExp(input logic v);
`ifdef WATCHDOG_WARN_EN
        return v;
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic nres, input logic [7:0] tr, input logic w);
        exp_t e;
        e.name  = name;
        e.nres  = nres;
        e.trips = tr;
        e.warn  = warnExp(w);
        sbq.push_back(e);
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            WDCLK = 1'b1;
            applyStimulus(1);
            WDCLK = 1'b0;
            applyStimulus(1);
        end
    endtask

    task automatic busWrite(input logic rw, input logic [6:0] addr, input logic withTick);
        bus.nLDS        = 1'b0;
        bus.RW          = rw;
        bus.M68K_ADDR_U = addr;
        WDCLK           = withTick;
        applyStimulus(1);
        bus.nLDS        = 1'b1;
        bus.RW          = 1'b1;
        bus.M68K_ADDR_U = 7'd0;
        WDCLK           = 1'b0;
        applyStimulus(1);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL timeout: got no finish, expected finish within 1 ms");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        RST             = 1'b1;
        DOGE            = 1'b1;
        WDCLK           = 1'b0;
        bus.nLDS        = 1'b1;
        bus.RW          = 1'b1;
        bus.M68K_ADDR_U = 7'd0;

        applyStimulus(3);
        checkOutput("reset_state", 1'b0, 8'd0, 1'b0);
        RST = 1'b0;
        applyStimulus(1);
        checkOutput("bite_after_release", 1'b0, 8'd0, 1'b0);
        tick(7);
        checkOutput("hold_7_ticks", 1'b0, 8'd0, 1'b0);
        tick(1);
        checkOutput("release_after_hold", 1'b1, 8'd0, 1'b0);

        // Kicked before the trip point.
        tick(7);
        busWrite(1'b0, KICK_ADDR, 1'b0);
        tick(5);
        checkOutput("kick_5_ticks", 1'b1, 8'd0, 1'b0);
        tick(1);
        checkOutput("kick_6_ticks_warn", 1'b1, 8'd0, 1'b1);
        tick(1);
        checkOutput("kick_then_7", 1'b1, 8'd0, 1'b1);

        // Trip with single-cycle resolution of the output latency.
        busWrite(1'b0, KICK_ADDR, 1'b0);
        checkOutput("warn_cleared_by_kick", 1'b1, 8'd0, 1'b0);
        tick(7);
        WDCLK = 1'b1;
        applyStimulus(1);
        checkOutput("trip_edge_trips_first", 1'b1, 8'd1, 1'b1);
        WDCLK = 1'b0;
        applyStimulus(1);
        checkOutput("trip_nreset_low", 1'b0, 8'd1, 1'b0);

        // Kicks in BITE do not shorten the hold.
        tick(4);
        busWrite(1'b0, KICK_ADDR, 1'b0);
        tick(3);
        checkOutput("bite_kick_ignored", 1'b0, 8'd1, 1'b0);
        tick(1);
        checkOutput("bite_release", 1'b1, 8'd1, 1'b0);

        // Kick and tick together at CNT=7.
        tick(7);
        busWrite(1'b0, KICK_ADDR, 1'b1);
        checkOutput("kick_tick_no_trip", 1'b1, 8'd1, 1'b0);
        tick(7);
        checkOutput("kick_tick_cleared_cnt", 1'b1, 8'd1, 1'b1);

        // A read to the kick address is not a kick.
        busWrite(1'b1, KICK_ADDR, 1'b0);
        tick(1);
        checkOutput("read_not_kick_trips", 1'b0, 8'd2, 1'b0);
        tick(8);
        checkOutput("read_trip_release", 1'b1, 8'd2, 1'b0);

        // A write to a neighbouring address is not a kick.
        tick(7);
        busWrite(1'b0, 7'b0011001, 1'b0);
        tick(1);
        checkOutput("addr_mismatch_trips", 1'b0, 8'd3, 1'b0);

        // DOGE low releases BITE.
        tick(2);
        DOGE = 1'b0;
        applyStimulus(1);
        checkOutput("doge_off_state_edge", 1'b0, 8'd3, 1'b0);
        applyStimulus(1);
        checkOutput("doge_off_release", 1'b1, 8'd3, 1'b0);
        tick(20);
        checkOutput("doge_off_20_ticks", 1'b1, 8'd3, 1'b0);
        DOGE = 1'b1;
        applyStimulus(1);
        tick(7);
        checkOutput("doge_on_cnt_cleared", 1'b1, 8'd3, 1'b1);
        tick(1);
        checkOutput("doge_on_trip", 1'b0, 8'd4, 1'b0);
        tick(8);
        checkOutput("doge_on_release", 1'b1, 8'd4, 1'b0);

        // Saturate the trip counter.
        for (int i = 0; i < 300; i++) begin
            tick(16);
            if (i == 249) checkOutput("trips_254", 1'b1, 8'd254, 1'b0);
            if (i == 250) checkOutput("trips_255", 1'b1, 8'd255, 1'b0);
        end
        checkOutput("trips_saturated", 1'b1, 8'd255, 1'b0);

        // Reset with WDCLK high must not produce a false tick on release.
        RST   = 1'b1;
        WDCLK = 1'b1;
        applyStimulus(2);
        checkOutput("reset_clears_all", 1'b0, 8'd0, 1'b0);
        RST = 1'b0;
        applyStimulus(1);
        WDCLK = 1'b0;
        applyStimulus(1);
        tick(7);
        checkOutput("no_false_tick", 1'b0, 8'd0, 1'b0);
        tick(1);
        checkOutput("release_after_reset", 1'b1, 8'd0, 1'b0);

        applyStimulus(3);
        if (sbq.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
